// File: rtl/microcode_sequencer_pkg.sv
// Shared control-word bit positions and opcode encodings for the 8-bit CPU sequencer.
// Every block that drives or decodes the shared-bus control word imports this package.
package microcode_sequencer_pkg;

   // Control-word bit indices; bit 0 is reserved and always 0
   localparam int HLT = 15;
   localparam int MI  = 14;
   localparam int RI  = 13;
   localparam int RO  = 12;
   localparam int II  = 11;
   localparam int AI  = 10;
   localparam int AO  = 9;
   localparam int EO  = 8;
   localparam int SU  = 7;
   localparam int BI  = 6;
   localparam int OI  = 5;
   localparam int CE  = 4;
   localparam int CO  = 3;
   localparam int J   = 2;
   localparam int FI  = 1;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_STA = 4'd4,
      OP_LDI = 4'd5,
      OP_JMP = 4'd6,
      OP_JC  = 4'd7,
      OP_JZ  = 4'd8,
      OP_OUT = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   function automatic logic [15:0] cb(int idx);
      return 16'(1) << idx;
   endfunction

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Combinational microcode table: (step, opcode, flags) -> control word, end-of-instruction
// marker and undefined-opcode indication. Requires OP_W >= 4.
module microcode_rom
   import microcode_sequencer_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int STEP_W = 3,
   parameter int CTRL_W = 16
) (
   input  logic [STEP_W-1:0] step,
   input  logic [OP_W-1:0]   opcode,
   input  logic              carry_f,
   input  logic              zero_f,
   output logic [CTRL_W-1:0] ctrl_word,
   output logic              last,
   output logic              is_illegal
);

   logic [15:0] w;
   logic        op_oor;
   opcode_e     op;
   int unsigned s;

   // Opcode bits beyond the 4-bit table make the instruction undefined
   if (OP_W > 4) begin : g_wide_op
      assign op_oor = |opcode[OP_W-1:4];
   end else begin : g_narrow_op
      assign op_oor = 1'b0;
   end

   always_comb begin
      w          = '0;
      last       = 1'b0;
      is_illegal = 1'b0;
      op         = opcode_e'(opcode[3:0]);
      s          = 32'(step);
      if (s == 0) begin
         w = cb(CO) | cb(MI);
      end else if (s == 1) begin
         w = cb(RO) | cb(II) | cb(CE);
      end else if (op_oor) begin
         last       = 1'b1;
         is_illegal = (s == 2);
      end else begin
         // Any step past an instruction's defined end also reports last, so a
         // stray step value always recovers to fetch.
         last = 1'b1;
         case (op)
            OP_NOP: ;
            OP_OUT: if (s == 2) w = cb(AO) | cb(OI);
            OP_HLT: if (s == 2) w = cb(HLT);
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_JC, OP_JZ: begin
               if (s == 2) begin
                  w    = cb(CO) | cb(MI);
                  last = 1'b0;
               end else if (s == 3) begin
                  case (op)
                     OP_LDI:  w = cb(RO) | cb(AI) | cb(CE);
                     OP_JMP:  w = cb(RO) | cb(J);
                     OP_JC:   w = carry_f ? (cb(RO) | cb(J)) : cb(CE);
                     OP_JZ:   w = zero_f  ? (cb(RO) | cb(J)) : cb(CE);
                     default: begin
                        w    = cb(RO) | cb(MI) | cb(CE);
                        last = 1'b0;
                     end
                  endcase
               end else if (s == 4) begin
                  case (op)
                     OP_LDA:         w = cb(RO) | cb(AI);
                     OP_STA:         w = cb(AO) | cb(RI);
                     OP_ADD, OP_SUB: begin
                        w    = cb(RO) | cb(BI);
                        last = 1'b0;
                     end
                     default: ;
                  endcase
               end else if (s == 5 && (op == OP_ADD || op == OP_SUB)) begin
                  w = cb(EO) | cb(AI) | cb(FI) | ((op == OP_SUB) ? cb(SU) : 16'h0000);
               end
            end
            default: is_illegal = (s == 2);
         endcase
      end
      ctrl_word = CTRL_W'(w);
   end

endmodule

// File: rtl/microcode_sequencer.sv
// Control sequencer for the 8-bit CPU: microstep counter, latched ALU flags, halt/run,
// single-step gating and sticky illegal-opcode detection around the microcode table.
module microcode_sequencer
   import microcode_sequencer_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int STEP_W = 3,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   opcode,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              single_step,
   input  logic              step_req,
   input  logic              run,
   output logic [CTRL_W-1:0] ctrl,
   output logic [STEP_W-1:0] step,
   output logic              halted,
   output logic              illegal,
   output logic              carry_f,
   output logic              zero_f
);

   logic [CTRL_W-1:0] rom_ctrl;
   logic              rom_last;
   logic              rom_illegal;
   logic              adv;
   logic              hlt_now;

   microcode_rom #(
      .OP_W   (OP_W),
      .STEP_W (STEP_W),
      .CTRL_W (CTRL_W)
   ) u_rom (
      .step       (step),
      .opcode     (opcode),
      .carry_f    (carry_f),
      .zero_f     (zero_f),
      .ctrl_word  (rom_ctrl),
      .last       (rom_last),
      .is_illegal (rom_illegal)
   );

   // A stalled cycle drives an all-zero word so no enable fires twice
   assign adv     = !reset && !halted && (!single_step || step_req);
   assign ctrl    = adv ? rom_ctrl : '0;
   assign hlt_now = adv && rom_ctrl[HLT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step    <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         carry_f <= 1'b0;
         zero_f  <= 1'b0;
      end else begin
         if (adv)
            step <= (rom_last || hlt_now) ? '0 : step + STEP_W'(1);
         // Halt takes priority over a run request on the same edge
         if (hlt_now)
            halted <= 1'b1;
         else if (run)
            halted <= 1'b0;
         if (adv && rom_illegal)
            illegal <= 1'b1;
         if (adv && rom_ctrl[FI]) begin
            carry_f <= alu_carry;
            zero_f  <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed vector table, hand-written halt/single-step/
// illegal/reset sequences, then randomized traffic against a microprogram-list model.
module tb_microcode_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic        alu_carry, alu_zero, single_step, step_req, run;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted, illegal, carry_f, zero_f;

   int n_tests = 0;
   int n_fail  = 0;

   typedef logic [15:0] wq_t[$];
   typedef struct {
      logic [3:0]  op;
      logic        ac;
      logic        az;
      logic [15:0] c;
      logic [2:0]  s;
      logic        cf;
      logic        zf;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   microcode_sequencer #(.OP_W(4), .STEP_W(3), .CTRL_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .alu_carry   (alu_carry),
      .alu_zero    (alu_zero),
      .single_step (single_step),
      .step_req    (step_req),
      .run         (run),
      .ctrl        (ctrl),
      .step        (step),
      .halted      (halted),
      .illegal     (illegal),
      .carry_f     (carry_f),
      .zero_f      (zero_f)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Whole microprogram of one instruction, fetch included; its length marks the last step
   function automatic wq_t prog(input logic [3:0] op, input logic cf, input logic zf);
      wq_t q;
      q.push_back(16'h4008);
      q.push_back(16'h1810);
      case (op)
         4'd1: begin q.push_back(16'h4008); q.push_back(16'h5010); q.push_back(16'h1400); end
         4'd2: begin q.push_back(16'h4008); q.push_back(16'h5010); q.push_back(16'h1040); q.push_back(16'h0502); end
         4'd3: begin q.push_back(16'h4008); q.push_back(16'h5010); q.push_back(16'h1040); q.push_back(16'h0582); end
         4'd4: begin q.push_back(16'h4008); q.push_back(16'h5010); q.push_back(16'h2200); end
         4'd5: begin q.push_back(16'h4008); q.push_back(16'h1410); end
         4'd6: begin q.push_back(16'h4008); q.push_back(16'h1004); end
         4'd7: begin q.push_back(16'h4008); q.push_back(cf ? 16'h1004 : 16'h0010); end
         4'd8: begin q.push_back(16'h4008); q.push_back(zf ? 16'h1004 : 16'h0010); end
         4'd14: q.push_back(16'h0220);
         4'd15: q.push_back(16'h8000);
         default: q.push_back(16'h0000);
      endcase
      return q;
   endfunction

   function automatic void addv(input logic [3:0] op, input logic ac, input logic az,
                                input logic [15:0] c, input logic [2:0] s,
                                input logic cf, input logic zf);
      tbl.push_back('{op, ac, az, c, s, cf, zf});
   endfunction

   logic [15:0] lda_w [5] = '{16'h4008, 16'h1810, 16'h4008, 16'h5010, 16'h1400};

   initial begin
      int m_step;
      logic m_halt, m_ill, m_cf, m_zf, adv, last, hlt;
      logic [15:0] w, expc;
      wq_t q;

      reset = 1'b1; opcode = 4'd0; alu_carry = 1'b0; alu_zero = 1'b0;
      single_step = 1'b0; step_req = 1'b0; run = 1'b0;
      #2;
      chk("reset_ctrl", 32'(ctrl), 32'h0);
      chk("reset_state", {27'd0, step, halted, illegal}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // NOP, ADD setting carry, JC taken, ADD setting zero, JC not taken, JZ taken
      addv(0,0,0,16'h4008,0,0,0); addv(0,0,0,16'h1810,1,0,0); addv(0,0,0,16'h0000,2,0,0);
      addv(2,0,0,16'h4008,0,0,0); addv(2,0,0,16'h1810,1,0,0); addv(2,0,0,16'h4008,2,0,0);
      addv(2,0,0,16'h5010,3,0,0); addv(2,0,0,16'h1040,4,0,0); addv(2,1,0,16'h0502,5,0,0);
      addv(7,0,0,16'h4008,0,1,0); addv(7,0,0,16'h1810,1,1,0); addv(7,0,0,16'h4008,2,1,0);
      addv(7,0,0,16'h1004,3,1,0);
      addv(2,0,0,16'h4008,0,1,0); addv(2,0,0,16'h1810,1,1,0); addv(2,0,0,16'h4008,2,1,0);
      addv(2,0,0,16'h5010,3,1,0); addv(2,0,0,16'h1040,4,1,0); addv(2,0,1,16'h0502,5,1,0);
      addv(7,0,0,16'h4008,0,0,1); addv(7,0,0,16'h1810,1,0,1); addv(7,0,0,16'h4008,2,0,1);
      addv(7,0,0,16'h0010,3,0,1);
      addv(8,0,0,16'h4008,0,0,1); addv(8,0,0,16'h1810,1,0,1); addv(8,0,0,16'h4008,2,0,1);
      addv(8,0,0,16'h1004,3,0,1);
      foreach (tbl[i]) begin
         opcode = tbl[i].op; alu_carry = tbl[i].ac; alu_zero = tbl[i].az;
         #1;
         chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_step", i), 32'(step), 32'(tbl[i].s));
         chk($sformatf("tbl%0d_flags", i), {30'd0, carry_f, zero_f}, {30'd0, tbl[i].cf, tbl[i].zf});
         tick();
      end
      alu_carry = 1'b0; alu_zero = 1'b0;

      // Halt, hold, resume with a one-clock run pulse
      opcode = 4'd15;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hlt_ctrl", 32'(ctrl), (i == 0) ? 32'h4008 : (i == 1) ? 32'h1810 : 32'h8000);
         chk("hlt_step", 32'(step), 32'(i));
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("halted_hold", {15'd0, ctrl, step, halted}, {15'd0, 16'h0, 3'd0, 1'b1});
         tick();
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      #1;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_ctrl", 32'(ctrl), 32'h4008);
      tick(); tick();
      run = 1'b1;
      #1;
      chk("hlt_run_same_ctrl", 32'(ctrl), 32'h8000);
      tick();
      run = 1'b0;
      #1;
      chk("hlt_wins", 32'(halted), 32'h1);
      run = 1'b1;
      tick();
      run = 1'b0;
      #1;
      chk("resume2", 32'(halted), 32'h0);

      // Single-step an LDA: five pulses, idle cycles drive nothing
      opcode = 4'd1; single_step = 1'b1;
      for (int p = 0; p < 5; p++) begin
         for (int k = 0; k < 3; k++) begin
            step_req = 1'b0;
            #1;
            chk("ss_idle", {13'd0, ctrl, step}, {13'd0, 16'h0, 3'(p)});
            tick();
         end
         step_req = 1'b1;
         #1;
         chk("ss_pulse", {13'd0, ctrl, step}, {13'd0, lda_w[p], 3'(p)});
         tick();
      end
      step_req = 1'b0;
      #1;
      chk("ss_done_step", 32'(step), 32'h0);
      single_step = 1'b0;

      // Undefined opcode, then asynchronous reset in the middle of an ADD
      opcode = 4'd9;
      tick(); tick();
      #1;
      chk("ill_s2_ctrl", {13'd0, ctrl, step}, {13'd0, 16'h0, 3'd2});
      tick();
      chk("ill_set", {30'd0, illegal, 1'b0}, {30'd0, 1'b1, 1'b0});
      opcode = 4'd2;
      repeat (4) tick();
      #1;
      chk("ill_sticky", {28'd0, step, illegal}, {28'd0, 3'd4, 1'b1});
      chk("pre_reset_zf", 32'(zero_f), 32'h1);
      reset = 1'b1;
      #1;
      chk("async_reset", {9'd0, ctrl, step, halted, illegal, carry_f, zero_f}, 32'h0);
      tick();
      reset = 1'b0;

      // Randomized traffic against the microprogram model
      m_step = 0; m_halt = 0; m_ill = 0; m_cf = 0; m_zf = 0;
      for (int n = 0; n < 3000; n++) begin
         if (m_step == 0) opcode = 4'($urandom_range(0, 15));
         single_step = ($urandom_range(0, 3) == 0);
         step_req    = 1'($urandom_range(0, 1));
         run         = ($urandom_range(0, 7) == 0);
         alu_carry   = 1'($urandom_range(0, 1));
         alu_zero    = 1'($urandom_range(0, 1));
         #1;
         q    = prog(opcode, m_cf, m_zf);
         adv  = !m_halt && (!single_step || step_req);
         w    = q[m_step];
         expc = adv ? w : 16'h0;
         chk("rnd", {8'd0, ctrl, 1'b0, step, halted, illegal, carry_f, zero_f},
                    {8'd0, expc, 1'b0, 3'(m_step), m_halt, m_ill, m_cf, m_zf});
         hlt  = adv && (m_step == 2) && (opcode == 4'd15);
         last = (m_step == q.size() - 1);
         if (adv) begin
            if (w[1]) begin m_cf = alu_carry; m_zf = alu_zero; end
            if (m_step == 2 && opcode inside {[4'd9:4'd13]}) m_ill = 1'b1;
            m_step = last ? 0 : m_step + 1;
         end
         if (hlt) m_halt = 1'b1;
         else if (run) m_halt = 1'b0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
